// File: rtl/m65_matrix_scancoder_if.sv
// Matrix-to-scancode bus: snapshot input side plus the PS/2-style event outputs.
// The master drives snapshots; the slave is the scancoder.
interface m65_matrix_scancoder_if #(
    parameter int NKEYS = 72
);
    logic [NKEYS-1:0] matrix;
    logic             matrix_valid;
    logic             scan_received;
    logic [7:0]       scancode;
    logic             extended;
    logic             released;
    logic             busy;
    logic             overrun;

    modport master (
        output matrix, matrix_valid,
        input  scan_received, scancode, extended, released, busy, overrun
    );

    modport slave (
        input  matrix, matrix_valid,
        output scan_received, scancode, extended, released, busy, overrun
    );
endinterface

// File: rtl/m65_matrix_scancoder.sv
// MEGA65 keyboard matrix to PS/2 set-2 event converter.
// Each accepted snapshot is diffed against the last reported key state and one
// make/break event is emitted per changed, mapped key, lowest index first.
module m65_matrix_scancoder #(
    parameter int NKEYS     = 72,
    parameter int EVENT_GAP = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    m65_matrix_scancoder_if.slave  bus
);
    localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int GW = (EVENT_GAP > 1) ? $clog2(EVENT_GAP) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NKEYS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(EVENT_GAP - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, GAP} state_t;

    state_t           state;
    logic [NKEYS-1:0] snap;
    logic [NKEYS-1:0] keystate;
    logic [IW-1:0]    idx;
    logic [GW-1:0]    gap_cnt;
    logic             scan_received_q;
    logic [7:0]       scancode_q;
    logic             extended_q;
    logic             released_q;
    logic             busy_q;
    logic             overrun_q;

    logic [9:0]       cur_map;
    logic             snap_bit;
    logic             key_bit;

    // Map ROM: {valid, ext, code[7:0]} per matrix position, MEGA65 layout.
    function automatic logic [9:0] map_entry(input logic [IW-1:0] i);
        map_entry = 10'b0;
        case (int'(i))
            0:  map_entry = {2'b10, 8'h66};
            1:  map_entry = {2'b10, 8'h5A};
            2:  map_entry = {2'b11, 8'h74};
            3:  map_entry = {2'b10, 8'h83};
            4:  map_entry = {2'b10, 8'h05};
            5:  map_entry = {2'b10, 8'h04};
            6:  map_entry = {2'b10, 8'h03};
            7:  map_entry = {2'b11, 8'h72};
            8:  map_entry = {2'b10, 8'h26};
            9:  map_entry = {2'b10, 8'h1D};
            10: map_entry = {2'b10, 8'h1C};
            11: map_entry = {2'b10, 8'h25};
            12: map_entry = {2'b10, 8'h1A};
            13: map_entry = {2'b10, 8'h1B};
            14: map_entry = {2'b10, 8'h24};
            15: map_entry = {2'b10, 8'h12};
            16: map_entry = {2'b10, 8'h2E};
            17: map_entry = {2'b10, 8'h2D};
            18: map_entry = {2'b10, 8'h23};
            19: map_entry = {2'b10, 8'h36};
            20: map_entry = {2'b10, 8'h21};
            21: map_entry = {2'b10, 8'h2B};
            22: map_entry = {2'b10, 8'h2C};
            23: map_entry = {2'b10, 8'h22};
            24: map_entry = {2'b10, 8'h3D};
            25: map_entry = {2'b10, 8'h35};
            26: map_entry = {2'b10, 8'h34};
            27: map_entry = {2'b10, 8'h3E};
            28: map_entry = {2'b10, 8'h32};
            29: map_entry = {2'b10, 8'h33};
            30: map_entry = {2'b10, 8'h3C};
            31: map_entry = {2'b10, 8'h2A};
            32: map_entry = {2'b10, 8'h46};
            33: map_entry = {2'b10, 8'h43};
            34: map_entry = {2'b10, 8'h3B};
            35: map_entry = {2'b10, 8'h45};
            36: map_entry = {2'b10, 8'h3A};
            37: map_entry = {2'b10, 8'h42};
            38: map_entry = {2'b10, 8'h44};
            39: map_entry = {2'b10, 8'h31};
            41: map_entry = {2'b10, 8'h4D};
            42: map_entry = {2'b10, 8'h4B};
            43: map_entry = {2'b10, 8'h4E};
            44: map_entry = {2'b10, 8'h49};
            45: map_entry = {2'b10, 8'h52};
            46: map_entry = {2'b10, 8'h54};
            47: map_entry = {2'b10, 8'h41};
            49: map_entry = {2'b10, 8'h5B};
            50: map_entry = {2'b10, 8'h4C};
            51: map_entry = {2'b11, 8'h6C};
            52: map_entry = {2'b10, 8'h59};
            53: map_entry = {2'b10, 8'h55};
            55: map_entry = {2'b10, 8'h4A};
            56: map_entry = {2'b10, 8'h16};
            57: map_entry = {2'b10, 8'h0E};
            58: map_entry = {2'b10, 8'h14};
            59: map_entry = {2'b10, 8'h1E};
            60: map_entry = {2'b10, 8'h29};
            61: map_entry = {2'b10, 8'h11};
            62: map_entry = {2'b10, 8'h15};
            65: map_entry = {2'b10, 8'h0D};
            71: map_entry = {2'b10, 8'h76};
            default: map_entry = 10'b0;
        endcase
    endfunction

    assign cur_map  = map_entry(idx);
    assign snap_bit = snap[idx];
    assign key_bit  = keystate[idx];

    assign bus.scan_received = scan_received_q;
    assign bus.scancode      = scancode_q;
    assign bus.extended      = extended_q;
    assign bus.released      = released_q;
    assign bus.busy          = busy_q;
    assign bus.overrun       = overrun_q;

    // Scan FSM; event outputs are loaded on the SCAN->EMIT transition so the strobe is visible during EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            snap            <= '0;
            keystate        <= '0;
            idx             <= '0;
            gap_cnt         <= '0;
            scan_received_q <= 1'b0;
            scancode_q      <= 8'h00;
            extended_q      <= 1'b0;
            released_q      <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            scan_received_q <= 1'b0;
            if (bus.matrix_valid && state != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.matrix_valid) begin
                        snap   <= bus.matrix;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (snap_bit != key_bit && cur_map[9]) begin
                        scancode_q      <= cur_map[7:0];
                        extended_q      <= cur_map[8];
                        released_q      <= ~snap_bit;
                        scan_received_q <= 1'b1;
                        state           <= EMIT;
                    end else begin
                        keystate[idx] <= snap_bit;
                        if (idx == LAST_IDX) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    keystate[idx] <= snap_bit;
                    gap_cnt       <= GAP_LOAD;
                    state         <= GAP;
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (idx == LAST_IDX) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m65_matrix_scancoder.sv
// Testbench for m65_matrix_scancoder: directed snapshots, expected events queued
// by the stimulus side and checked by an independent strobe monitor.
module tb_m65_matrix_scancoder;
    localparam int NKEYS     = 72;
    localparam int EVENT_GAP = 2;
    localparam int PER_EVENT = EVENT_GAP + 1;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        int         cyc;
    } event_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    event_t sb[$];

    m65_matrix_scancoder_if #(.NKEYS(NKEYS)) bus ();

    m65_matrix_scancoder #(.NKEYS(NKEYS), .EVENT_GAP(EVENT_GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and cycle counter used to timestamp strobes.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_event(input logic [7:0] code, input logic ext, input logic rel, input int at);
        event_t e;
        e.code = code;
        e.ext  = ext;
        e.rel  = rel;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Called on a falling edge; matrix_valid is high for exactly one cycle, t is that cycle.
    task automatic apply_stimulus(input logic [NKEYS-1:0] m, output int t);
        bus.matrix       = m;
        bus.matrix_valid = 1'b1;
        t                = cyc;
        @(negedge clk);
        bus.matrix_valid = 1'b0;
    endtask

    // Counts cycles with busy high until it drops, then requires all expected events to have appeared.
    task automatic wait_idle(input int exp_busy, input string name);
        int n = 0;
        while (bus.busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (bus.busy === 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
        end else if (exp_busy >= 0) begin
            check_output(name, n, exp_busy);
        end
        check_output({name, "_drained"}, sb.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_scan_received"}, bus.scan_received, 0);
        check_output({name, "_scancode"}, bus.scancode, 8'h00);
        check_output({name, "_extended"}, bus.extended, 0);
        check_output({name, "_released"}, bus.released, 0);
        check_output({name, "_busy"}, bus.busy, 0);
        check_output({name, "_overrun"}, bus.overrun, 0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        event_t e;
        if (bus.scan_received === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got code 0x%0h ext %0d rel %0d at cycle %0d, expected no event",
                         bus.scancode, bus.extended, bus.released, cyc);
            end else begin
                e = sb.pop_front();
                check_output("ev_code", bus.scancode, e.code);
                check_output("ev_ext", bus.extended, e.ext);
                check_output("ev_rel", bus.released, e.rel);
                check_output("ev_cycle", cyc, e.cyc);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        logic [NKEYS-1:0] m;
        int t;
        int t_drop;

        bus.matrix       = '0;
        bus.matrix_valid = 1'b0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        m = '0; m[10] = 1'b1;
        apply_stimulus(m, t);
        push_event(8'h1C, 1'b0, 1'b0, t + 2 + 10);
        wait_idle(NKEYS + PER_EVENT, "busy_a_press");

        m = '0;
        apply_stimulus(m, t);
        push_event(8'h1C, 1'b0, 1'b1, t + 2 + 10);
        wait_idle(NKEYS + PER_EVENT, "busy_a_release");

        apply_stimulus(m, t);
        wait_idle(NKEYS, "busy_no_change");

        m = '0; m[2] = 1'b1; m[15] = 1'b1;
        apply_stimulus(m, t);
        push_event(8'h74, 1'b1, 1'b0, t + 2 + 2);
        push_event(8'h12, 1'b0, 1'b0, t + 2 + 15 + PER_EVENT);
        wait_idle(NKEYS + 2 * PER_EVENT, "busy_two_press");
        repeat (3) @(negedge clk);
        check_output("hold_scancode", bus.scancode, 8'h12);
        check_output("hold_extended", bus.extended, 0);
        check_output("hold_released", bus.released, 0);

        m = '0;
        apply_stimulus(m, t);
        push_event(8'h74, 1'b1, 1'b1, t + 2 + 2);
        push_event(8'h12, 1'b0, 1'b1, t + 2 + 15 + PER_EVENT);
        wait_idle(NKEYS + 2 * PER_EVENT, "busy_two_release");
        check_output("hold_released_break", bus.released, 1);

        m = '0; m[64] = 1'b1;
        apply_stimulus(m, t);
        wait_idle(NKEYS, "busy_unmapped_set");
        m = '0;
        apply_stimulus(m, t);
        wait_idle(NKEYS, "busy_unmapped_clear");
        check_output("overrun_before", bus.overrun, 0);

        m = '0; m[1] = 1'b1;
        apply_stimulus(m, t);
        push_event(8'h5A, 1'b0, 1'b0, t + 2 + 1);
        m[12] = 1'b1;
        apply_stimulus(m, t_drop);
        wait_idle(-1, "busy_overrun");
        check_output("overrun_set", bus.overrun, 1);

        m = '0; m[12] = 1'b1;
        apply_stimulus(m, t);
        push_event(8'h5A, 1'b0, 1'b1, t + 2 + 1);
        push_event(8'h1A, 1'b0, 1'b0, t + 2 + 12 + PER_EVENT);
        wait_idle(NKEYS + 2 * PER_EVENT, "busy_net_change");
        check_output("overrun_sticky", bus.overrun, 1);

        m = '0; m[3] = 1'b1;
        apply_stimulus(m, t);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("midscan_reset");

        apply_stimulus(m, t);
        push_event(8'h83, 1'b0, 1'b0, t + 2 + 3);
        wait_idle(NKEYS + PER_EVENT, "busy_after_reset");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m65_matrix_scancoder.md
# m65_matrix_scancoder

Converts the MEGA65 keyboard matrix snapshots into the PS/2-style key event stream: scan strobe, 8-bit scancode, extended flag and released flag. It sits between the MEGA65 matrix reader and the consumers inside `ps2_keyb`: `kb_special_functions`, `keyboard_pressed_status`, `scancode_to_speccy` and the KBSTATUS/SCANCODE registers. It drives the `nueva_tecla`, `kbcode`, `extended` and `released` nets. Each snapshot is diffed against a stored key-state vector, and one event is emitted per changed, mapped key.

## Interface
Parameters:
- `NKEYS`, 72, number of matrix positions (index 0..NKEYS-1).
- `EVENT_GAP`, 2, minimum cycles between consecutive `scan_received` strobes (≥1).

Ports:
- `clk`  in  1  system clock; one clock domain, no other clocks.
- `rst`  in  1  synchronous, active-high reset.
- `matrix`  in  NKEYS  current key state; bit n = 1 means key n pressed. Active-high; inversion is done upstream.
- `matrix_valid`  in  1  one-cycle pulse; `matrix` is stable and sampled this cycle.
- `scan_received`  out  1  one-cycle strobe; new event on `scancode`/`extended`/`released`.
- `scancode`  out  8  PS/2 set-2 code, without E0/F0 prefixes.
- `extended`  out  1  code belongs to the E0 set.
- `released`  out  1  1 = key up (break), 0 = key down (make).
- `busy`  out  1  snapshot being processed.
- `overrun`  out  1  sticky; a snapshot arrived while busy. Cleared only by `rst`.

## Operation
- Internal state:
  - `keystate[NKEYS]`, last reported state per key.
  - `snap[NKEYS]`, latched snapshot.
  - `idx` counter, width ceil(log2(NKEYS)).
  - Gap counter.
  - Constant map ROM, index → {`valid`, `ext`, `code[7:0]`}.
- Required map entries (the rest per the MEGA65 layout):
  - 0 INST/DEL → 0x66
  - 1 RETURN → 0x5A
  - 2 CRSR-RIGHT → ext 0x74
  - 3 F7 → 0x83
  - 10 A → 0x1C
  - 12 Z → 0x1A
  - 15 LEFT-SHIFT → 0x12
  - 71 RUN/STOP → 0x76
  - Unmapped positions have `valid`=0.
- FSM states: IDLE, SCAN, EMIT, GAP.
  - IDLE: on `matrix_valid`, latch `snap`<=`matrix`, `idx`<=0, go to SCAN.
  - SCAN: compare `snap[idx]` with `keystate[idx]`.
    - Equal: advance `idx`.
    - Differ and unmapped: `keystate[idx]`<=`snap[idx]` silently, advance `idx`.
    - Differ and mapped: go to EMIT.
    - When the last index is processed without going to EMIT, go to IDLE.
  - EMIT (one cycle):
    - Register `scancode`<=code, `extended`<=ext, `released`<=~`snap[idx]`, `scan_received`<=1.
    - Update `keystate[idx]`<=`snap[idx]`.
    - Load the gap counter, go to GAP.
  - GAP: hold for EVENT_GAP-1 further cycles, then return to SCAN at `idx`+1. If `idx` was NKEYS-1, go to IDLE instead.
- Events are emitted in ascending index order within one snapshot.
- A press and release of the same key between two snapshots produces no event.
- `matrix_valid` while `busy`: the snapshot is ignored and `overrun`<=1. No key state is lost, because the next accepted snapshot is diffed against `keystate`.
- `scancode`, `extended` and `released` hold their last value between strobes; the KBSTATUS/SCANCODE register reads depend on this.

## Timing
- Reset values: `scan_received`=0, `scancode`=0x00, `extended`=0, `released`=0, `busy`=0, `overrun`=0, `keystate`=all 0, FSM=IDLE.
- `rst` mid-scan aborts immediately. Keys still held are reported as presses on the first snapshot after reset.
- `matrix_valid` in cycle T: `busy`=1 from T+1. SCAN examines index k in cycle T+1+k, assuming no earlier events in that snapshot.
- A changed mapped key at index k gives `scan_received` high in cycle T+2+k, for exactly one cycle.
- Each event adds EVENT_GAP+1 cycles to the scan. Consecutive strobes are ≥ EVENT_GAP+1 cycles apart, which is ≥ EVENT_GAP.
- `busy` falls the cycle after the last index is processed. No-change snapshot: `busy` high for NKEYS cycles.
- `matrix_valid` in the same cycle `busy` falls is accepted, because the FSM is already in IDLE.

## Test plan
- Reset, then snapshot with bit 10 set → one strobe: `scancode`=0x1C, `extended`=0, `released`=0, in cycle T+12. `busy` low after 72+3 cycles.
- Next snapshot with all zeros → one strobe: 0x1C with `released`=1. A repeated all-zero snapshot → no strobe.
- Bits 2 and 15 set together → strobe 0x74 with `extended`=1, then 0x12 ≥3 cycles later. Order is ascending.
- Snapshot with only unmapped bit 64 set → no strobe, `busy` for 72 cycles. Clearing bit 64 → no strobe.
- Second `matrix_valid` while busy → `overrun`=1 and the snapshot is dropped. A following accepted snapshot reports the net change only.
- Assert `rst` mid-scan with bit 3 held, then resend the snapshot → all outputs at reset values, then strobe 0x83 with `released`=0.
